// File: rtl/apb_pkg.sv
`default_nettype none
//============================================================================
// Module : apb_pkg
// Brief  : Shared APB types and constants for the master bridge and responder
// Rev    : 1.0  initial release
//============================================================================
package apb_pkg;

  localparam int APB_ADDR_MSB = 23;
  localparam int APB_ADDR_LSB = 2;
  localparam int APB_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  timeout;
  } apb_rsp_t;

  localparam apb_rsp_t c_RSP_NONE = '{rdata: '0, timeout: 1'b0};

  // A limit of 0 still needs a 1-bit register so the counter elaborates.
  function automatic int unsigned wait_cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`default_nettype none
//============================================================================
// Module : apb_timeout_counter
// Brief  : Saturating wait-state counter with clear/enable and a limit hit flag
// Rev    : 1.0  initial release
//============================================================================
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned   c_W   = wait_cnt_width(LIMIT);
  localparam logic [c_W-1:0] c_MAX = c_W'(LIMIT);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != c_MAX)) begin
      r_count <= r_count + c_W'(1);
    end
  end

  // hit means the increment taken this cycle lands on LIMIT; it does not
  // depend on en so the caller can gate it without a combinational loop.
  if (LIMIT == 0) begin : g_no_timeout
    assign hit = 1'b0;
  end else begin : g_timeout
    localparam logic [c_W-1:0] c_LAST = c_W'(LIMIT - 1);
    assign hit = (r_count == c_LAST);
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
//============================================================================
// Module : apb_master_bridge
// Brief  : valid/ready request port to single APB transfers with timeout guard
// Rev    : 1.0  initial release
//============================================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [APB_ADDR_MSB:APB_ADDR_LSB] req_addr,
  input  logic [APB_DATA_W-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [APB_DATA_W-1:0]            rsp_rdata,
  output logic                             rsp_timeout,
  output logic [APB_ADDR_MSB:APB_ADDR_LSB] paddr,
  output logic                             penable,
  output logic                             pwrite,
  output logic [APB_DATA_W-1:0]            pwdata,
  output logic                             psel,
  input  logic                             pready,
  input  logic [APB_DATA_W-1:0]            prdata
);

  apb_mst_state_e r_state;
  apb_mst_state_e w_state_nxt;

  logic     r_rst_done;
  logic     w_accept;
  logic     w_done;
  logic     w_timeout;
  logic     w_cnt_clr;
  logic     w_cnt_en;
  logic     w_hit;
  logic     r_rsp_valid;
  apb_rsp_t r_rsp;

  apb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_cnt_clr),
    .en      (w_cnt_en),
    .hit     (w_hit)
  );

  // Keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = r_rst_done;
        if (req_valid && r_rst_done) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        psel        = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready takes priority over a limit reached in the same cycle.
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_hit) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (w_accept) begin
      paddr  <= req_addr;
      pwrite <= req_write;
      pwdata <= req_wdata;
    end
  end

  // Response fields are forced to zero whenever no completion is reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= c_RSP_NONE;
    end else begin
      r_rsp_valid   <= w_done || w_timeout;
      r_rsp.rdata   <= (w_done && !pwrite) ? prdata : '0;
      r_rsp.timeout <= w_timeout;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp.rdata;
  assign rsp_timeout = r_rsp.timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
//============================================================================
// Module : tb_apb_master_bridge
// Brief  : Directed self-checking bench for apb_master_bridge
// Rev    : 1.0  initial release
//============================================================================
module tb_apb_master_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [23:2] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [23:2] paddr;
  logic        penable, pwrite, psel, pready;
  logic [31:0] pwdata, prdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [23:2] z_req_addr;
  logic [31:0] z_req_wdata;
  logic        z_rsp_valid, z_rsp_timeout;
  logic [31:0] z_rsp_rdata;
  logic [23:2] z_paddr;
  logic        z_penable, z_pwrite, z_psel, z_pready;
  logic [31:0] z_pwdata, z_prdata;

  apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .psel(psel), .pready(pready), .prdata(prdata)
  );

  apb_master_bridge #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_timeout(z_rsp_timeout),
    .paddr(z_paddr), .penable(z_penable), .pwrite(z_pwrite), .pwdata(z_pwdata),
    .psel(z_psel), .pready(z_pready), .prdata(z_prdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k, last, nrsp, bad;
    logic acc, rv;

    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_pready = 1'b0; z_prdata = '0;

    // Reset state
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_psel",      32'(psel), 0);
    chk("rst_penable",   32'(penable), 0);
    chk("rst_pwrite",    32'(pwrite), 0);
    chk("rst_paddr",     32'(paddr), 0);
    chk("rst_pwdata",    pwdata, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_tmo",   32'(rsp_timeout), 0);
    reset_n = 1'b1;
    tick;
    chk("rel_req_ready", 32'(req_ready), 1);

    // Zero-wait write to byte address 0x10 (word 0x4); prdata noise must not leak
    pready = 1'b1; prdata = 32'h5555AAAA;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 22'h000004; req_wdata = 32'hDEADBEEF;
    tick;
    req_valid = 1'b0;
    chk("w0_setup_psel",    32'(psel), 1);
    chk("w0_setup_penable", 32'(penable), 0);
    chk("w0_setup_ready",   32'(req_ready), 0);
    chk("w0_paddr",         32'(paddr), 32'h4);
    chk("w0_pwdata",        pwdata, 32'hDEADBEEF);
    chk("w0_pwrite",        32'(pwrite), 1);
    tick;
    chk("w0_acc_psel",      32'(psel), 1);
    chk("w0_acc_penable",   32'(penable), 1);
    chk("w0_acc_rsp",       32'(rsp_valid), 0);
    tick;
    chk("w0_rsp_valid",     32'(rsp_valid), 1);
    chk("w0_rsp_tmo",       32'(rsp_timeout), 0);
    chk("w0_rsp_rdata",     rsp_rdata, 0);
    chk("w0_rsp_psel",      32'(psel), 0);
    chk("w0_rsp_penable",   32'(penable), 0);
    chk("w0_rsp_ready",     32'(req_ready), 1);
    tick;
    chk("w0_rsp_clear",     32'(rsp_valid), 0);
    chk("w0_hold_pwdata",   pwdata, 32'hDEADBEEF);

    // Read with 3 wait states; pready lands in the 4th ACCESS cycle == limit
    pready = 1'b0; prdata = 32'hBAD0BAD0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h2A5A5;
    tick;
    req_valid = 1'b0;
    chk("rd_setup_paddr", 32'(paddr), 32'h2A5A5);
    chk("rd_pwrite",      32'(pwrite), 0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("rd_acc_penable", 32'(penable), 1);
      chk("rd_acc_paddr",   32'(paddr), 32'h2A5A5);
      chk("rd_acc_norsp",   32'(rsp_valid), 0);
      if (i == 4) begin
        pready = 1'b1; prdata = 32'h12345678;
      end
    end
    tick;
    pready = 1'b0; prdata = 32'hBAD0BAD0;
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_tmo",   32'(rsp_timeout), 0);
    tick;
    chk("rd_rsp_clear", 32'(rsp_valid), 0);
    chk("rd_rdata_clr", rsp_rdata, 0);

    // Timeout after 4 ACCESS cycles with pready held low
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h3FFFFF;
    tick;
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("to_acc_penable", 32'(penable), 1);
      chk("to_acc_norsp",   32'(rsp_valid), 0);
    end
    tick;
    chk("to_rsp_valid",   32'(rsp_valid), 1);
    chk("to_rsp_tmo",     32'(rsp_timeout), 1);
    chk("to_rsp_rdata",   rsp_rdata, 0);
    chk("to_rsp_psel",    32'(psel), 0);
    chk("to_rsp_penable", 32'(penable), 0);
    chk("to_rsp_ready",   32'(req_ready), 1);
    tick;
    chk("to_clear_valid", 32'(rsp_valid), 0);
    chk("to_clear_tmo",   32'(rsp_timeout), 0);

    // Back-to-back: four queued writes, one accept every 3 cycles
    pready = 1'b1; prdata = '0;
    k = 0; last = 0; nrsp = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 22'h100; req_wdata = 32'hA0000000;
    for (int cyc = 0; cyc < 20; cyc++) begin
      acc = req_valid && req_ready;
      rv  = rsp_valid;
      if (rv) nrsp++;
      if (acc) begin
        if (k > 0) begin
          chk("b2b_spacing", 32'(cyc - last), 3);
          chk("b2b_overlap", 32'(rv), 1);
        end
        last = cyc;
        k++;
      end
      tick;
      if (acc) begin
        chk("b2b_pwdata", pwdata, 32'hA0000000 + 32'(k - 1));
        chk("b2b_paddr",  32'(paddr), 32'h100 + 32'(k - 1));
        if (k < 4) begin
          req_addr  = 22'h100 + 22'(k);
          req_wdata = 32'hA0000000 + 32'(k);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts",   32'(k), 4);
    chk("b2b_responses", 32'(nrsp), 4);

    // TIMEOUT_CYCLES=0 instance: 100 wait states then completion
    pready = 1'b0;
    z_pready = 1'b0; z_prdata = 32'hBAD0BAD0;
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 22'h1234;
    tick;
    z_req_valid = 1'b0;
    nrsp = 0; bad = 0;
    for (int i = 1; i <= 101; i++) begin
      tick;
      if (z_rsp_valid) nrsp++;
      if (z_penable !== 1'b1) bad++;
      if (i == 101) begin
        z_pready = 1'b1; z_prdata = 32'h0F0F0F0F;
      end
    end
    chk("z_no_early_rsp", 32'(nrsp), 0);
    chk("z_penable_held", 32'(bad), 0);
    tick;
    z_pready = 1'b0;
    chk("z_rsp_valid", 32'(z_rsp_valid), 1);
    chk("z_rsp_tmo",   32'(z_rsp_timeout), 0);
    chk("z_rsp_rdata", z_rsp_rdata, 32'h0F0F0F0F);

    // Reset during a wait state
    pready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 22'h00ABC; req_wdata = 32'h600DF00D;
    tick;
    req_valid = 1'b0;
    tick; tick;
    chk("mr_in_access", 32'(penable), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_psel",      32'(psel), 0);
    chk("mr_penable",   32'(penable), 0);
    chk("mr_paddr",     32'(paddr), 0);
    chk("mr_pwdata",    pwdata, 0);
    chk("mr_pwrite",    32'(pwrite), 0);
    chk("mr_req_ready", 32'(req_ready), 0);
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    pready = 1'b1;
    tick; tick;
    chk("mr_hold_rsp",  32'(rsp_valid), 0);
    reset_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (rsp_valid) nrsp++;
    end
    chk("mr_no_rsp_after", 32'(nrsp), 0);
    chk("mr_ready_after",  32'(req_ready), 1);
    prdata = 32'hCAFEF00D;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h155;
    tick;
    req_valid = 1'b0;
    chk("mr2_paddr", 32'(paddr), 32'h155);
    tick; tick;
    chk("mr2_rsp_valid", 32'(rsp_valid), 1);
    chk("mr2_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    chk("mr2_rsp_tmo",   32'(rsp_timeout), 0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that turns a simple valid/ready request port into single APB transfers on `apb_bus`, driving both the address/data group and the select/response group. It sits between an internal command source (CPU shim, DMA or test sequencer) and the peripheral fabric. It owns the SETUP/ACCESS sequencing, wait-state handling and a timeout guard against slaves that never assert `pready`.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles before forced termination; 0 disables the timeout.

Ports:
- `clk` input 1: the single clock; all logic is rising-edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: bridge can accept a request.
- `req_write` input 1: 1 for write, 0 for read.
- `req_addr` input [23:2]: word address.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` output 32: read data; 0 for writes and timeouts.
- `rsp_timeout` output 1: qualifies `rsp_valid`; the transfer was aborted.
- `paddr` output [23:2], `penable` output 1, `pwrite` output 1, `pwdata` output 32: APB address/data group.
- `psel` output 1: APB select.
- `pready` input 1, `prdata` input 32: APB response.

## Operation

- States: IDLE, SETUP, ACCESS.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` && `req_ready`, register addr, write and wdata onto `paddr`, `pwrite`, `pwdata`, then go to SETUP.
- SETUP:
  - `psel`=1, `penable`=0.
  - Always lasts one cycle, then go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1.
  - Each cycle, sample `pready` at the rising edge.
  - If `pready`=1: complete the transfer, capture `prdata` (reads only), go to IDLE.
  - Else, when the wait counter reaches `TIMEOUT_CYCLES` (nonzero), abort and go to IDLE with the timeout flag set.
- Wait counter:
  - Width clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to ACCESS; increments each ACCESS cycle without `pready`.
  - Saturating, never wraps.
- `paddr`, `pwrite`, `pwdata`:
  - Change only on request acceptance.
  - Stable from SETUP through completion.
  - Hold their last value in IDLE (no toggling).
- `req_ready`=0 in SETUP and ACCESS. Requests presented then are not accepted and must be held by the source.
- Completion edge: the next cycle has `rsp_valid`=1 and state IDLE. `req_ready`=1 in that same cycle, so a new request may be accepted while the response pulse is present.
- `pready` seen together with the timeout limit in the same cycle: `pready` wins; normal completion, `rsp_timeout`=0.
- Timeout: `rsp_timeout`=1, `rsp_rdata`=0, `psel` and `penable` drop in the response cycle.
- `pready` and `prdata` are ignored outside ACCESS.
- Reset mid-transfer:
  - All outputs return to reset values immediately (asynchronous).
  - No response is generated for the aborted transfer.

## Timing

- Reset values:
  - `req_ready`=0 while `reset_n`=0, 1 from the first cycle after release.
  - `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_timeout`=0.
- Accept at edge N: SETUP during cycle N+1, ACCESS from N+2.
- Zero-wait slave (`pready`=1 in the first ACCESS cycle): completion at edge N+3, `rsp_valid` during cycle N+3. Accept-to-response latency is 3 cycles.
- Each wait state adds one cycle.
- Timeout: `rsp_valid` falls `TIMEOUT_CYCLES`+3 cycles after acceptance.
- Back-to-back throughput: one transfer per 3 cycles, because IDLE is overlapped with the response cycle.
- `rsp_rdata` and `rsp_timeout` are valid only while `rsp_valid`=1. Both are cleared to 0 in other cycles.

## Structure

- Shared package `apb_pkg`:
  - State enum `apb_mst_state_e` {IDLE, SETUP, ACCESS}.
  - Localparams `APB_ADDR_MSB`=23, `APB_ADDR_LSB`=2, `APB_DATA_W`=32.
  - Response struct `apb_rsp_t` {rdata, timeout}.
  - The matching APB slave-side responder reuses the same package.
- One sub-module: `apb_timeout_counter`, a saturating counter with clear, enable and a `hit` output.
- FSM and datapath registers stay in the top module.

## Test plan

- Zero-wait write: addr 0x000010, wdata 0xDEADBEEF, `pready` tied 1 -> `psel` high 2 cycles, `penable` high 1 cycle, `rsp_valid` 3 cycles after accept, `rsp_timeout`=0, `rsp_rdata`=0.
- Read with 3 wait states: `pready` asserted on the 4th ACCESS cycle with `prdata`=0x12345678 -> `rsp_rdata`=0x12345678, latency 6 cycles. `paddr` stable throughout and no `prdata` captured earlier.
- Timeout: `TIMEOUT_CYCLES`=4, `pready` held 0 -> abort after 4 ACCESS cycles, `rsp_timeout`=1, `rsp_rdata`=0, `psel`/`penable` low in the response cycle.
- Timeout boundary: `pready`=1 in exactly the 4th ACCESS cycle -> normal completion with `rsp_timeout`=0. Also check `TIMEOUT_CYCLES`=0 with 100 wait states -> completes normally.
- Back-to-back: `req_valid` held high with 4 queued requests -> exactly one accept per 3 cycles. Each accept coincides with the previous `rsp_valid` and no request is lost or duplicated.
- Reset mid-ACCESS: assert `reset_n`=0 during a wait state -> all outputs go to 0 immediately, no `rsp_valid`, and the next request after release runs normally.
